// File: rtl/div_arbiter_if.sv
// Requester-side and divider-side signal bundle for the shared divider arbiter.
// The arbiter connects through the slave modport; its environment uses master.
interface div_arbiter_if #(
  parameter int NUM_REQ        = 2,
  parameter int DIVIDEND_WIDTH = 64,
  parameter int DIVISOR_WIDTH  = 32
);
  logic [NUM_REQ-1:0]                req_valid;
  logic [NUM_REQ-1:0]                req_ready;
  logic [NUM_REQ*DIVIDEND_WIDTH-1:0] req_dividend;
  logic [NUM_REQ*DIVISOR_WIDTH-1:0]  req_divisor;
  logic [NUM_REQ-1:0]                rsp_valid;
  logic [DIVIDEND_WIDTH-1:0]         rsp_quotient;
  logic [DIVISOR_WIDTH-1:0]          rsp_remainder;
  logic                              rsp_overflow;
  logic                              div_valid_in;
  logic [DIVIDEND_WIDTH-1:0]         div_dividend;
  logic [DIVISOR_WIDTH-1:0]          div_divisor;
  logic [DIVIDEND_WIDTH-1:0]         div_quotient;
  logic [DIVISOR_WIDTH-1:0]          div_remainder;
  logic                              div_overflow;
  logic                              div_valid_out;
  logic                              busy;
  logic                              err_timeout;
  logic                              err_stray;

  modport slave (
    input  req_valid, req_dividend, req_divisor,
           div_quotient, div_remainder, div_overflow, div_valid_out,
    output req_ready, rsp_valid, rsp_quotient, rsp_remainder, rsp_overflow,
           div_valid_in, div_dividend, div_divisor, busy, err_timeout, err_stray
  );

  modport master (
    output req_valid, req_dividend, req_divisor,
           div_quotient, div_remainder, div_overflow, div_valid_out,
    input  req_ready, rsp_valid, rsp_quotient, rsp_remainder, rsp_overflow,
           div_valid_in, div_dividend, div_divisor, busy, err_timeout, err_stray
  );
endinterface

// File: rtl/div_arbiter.sv
// Round-robin arbiter sharing one variable-latency divider between NUM_REQ
// requesters, with divide-by-zero short-circuit and a hung-divider watchdog.
module div_arbiter #(
  parameter int NUM_REQ        = 2,
  parameter int DIVIDEND_WIDTH = 64,
  parameter int DIVISOR_WIDTH  = 32,
  parameter int TIMEOUT        = 256
) (
  input logic          clk,
  input logic          reset,
  div_arbiter_if.slave bus
);
  localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam int DW = DIVIDEND_WIDTH;
  localparam int SW = DIVISOR_WIDTH;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESPOND} state_t;

  state_t        state;
  logic [PW-1:0] rr_ptr;
  logic [PW-1:0] owner;
  logic [PW-1:0] winner;
  logic [PW-1:0] cand;
  logic          found;
  logic [CW-1:0] wd_count;
  logic [DW-1:0] win_dividend;
  logic [SW-1:0] win_divisor;

  // Scan from rr_ptr upward with wrap so the last owner goes to the back of the line.
  always_comb begin
    found  = 1'b0;
    winner = '0;
    cand   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = PW'((int'(rr_ptr) + k) % NUM_REQ);
      if (!found && bus.req_valid[cand]) begin
        found  = 1'b1;
        winner = cand;
      end
    end
  end

  always_comb begin
    bus.req_ready = '0;
    if (state == IDLE && found) bus.req_ready[winner] = 1'b1;
  end

  assign win_dividend = bus.req_dividend[int'(winner)*DW +: DW];
  assign win_divisor  = bus.req_divisor[int'(winner)*SW +: SW];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state             <= IDLE;
      rr_ptr            <= '0;
      owner             <= '0;
      wd_count          <= '0;
      bus.div_valid_in  <= 1'b0;
      bus.div_dividend  <= '0;
      bus.div_divisor   <= '0;
      bus.rsp_valid     <= '0;
      bus.rsp_quotient  <= '0;
      bus.rsp_remainder <= '0;
      bus.rsp_overflow  <= 1'b0;
      bus.busy          <= 1'b0;
      bus.err_timeout   <= 1'b0;
      bus.err_stray     <= 1'b0;
    end else begin
      bus.div_valid_in <= 1'b0;
      bus.rsp_valid    <= '0;
      // A result outside WAIT belongs to nobody, e.g. a late one after a timeout.
      if (bus.div_valid_out && state != WAIT) bus.err_stray <= 1'b1;
      unique case (state)
        IDLE: begin
          if (found) begin
            owner            <= winner;
            bus.div_dividend <= win_dividend;
            bus.div_divisor  <= win_divisor;
            bus.busy         <= 1'b1;
            if (win_divisor == '0) begin
              bus.rsp_quotient      <= '1;
              bus.rsp_remainder     <= '0;
              bus.rsp_overflow      <= 1'b1;
              bus.rsp_valid[winner] <= 1'b1;
              state                 <= RESPOND;
            end else begin
              bus.div_valid_in <= 1'b1;
              state            <= ISSUE;
            end
          end
        end
        ISSUE: begin
          wd_count <= '0;
          state    <= WAIT;
        end
        WAIT: begin
          if (bus.div_valid_out) begin
            bus.rsp_quotient     <= bus.div_quotient;
            bus.rsp_remainder    <= bus.div_remainder;
            bus.rsp_overflow     <= bus.div_overflow;
            bus.rsp_valid[owner] <= 1'b1;
            state                <= RESPOND;
          end else if (wd_count == CW'(TIMEOUT - 1)) begin
            bus.rsp_quotient     <= '1;
            bus.rsp_remainder    <= '0;
            bus.rsp_overflow     <= 1'b1;
            bus.err_timeout      <= 1'b1;
            bus.rsp_valid[owner] <= 1'b1;
            state                <= RESPOND;
          end else begin
            wd_count <= wd_count + 1'b1;
          end
        end
        RESPOND: begin
          rr_ptr   <= (owner == PW'(NUM_REQ - 1)) ? '0 : owner + 1'b1;
          bus.busy <= 1'b0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_div_arbiter.sv
// Self-checking bench for div_arbiter: an event-time reference model checked every
// cycle, a behavioural divider with programmable latency, and directed literal checks.
module tb_div_arbiter;
  localparam int N  = 2;
  localparam int DW = 64;
  localparam int SW = 32;
  localparam int TO = 16;

  logic clk;
  logic reset;

  div_arbiter_if #(.NUM_REQ(N), .DIVIDEND_WIDTH(DW), .DIVISOR_WIDTH(SW)) bus ();

  div_arbiter #(.NUM_REQ(N), .DIVIDEND_WIDTH(DW), .DIVISOR_WIDTH(SW), .TIMEOUT(TO)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_errors = 0;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("[TB] FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, act, exp);
    end
  endtask

  // Requester drivers
  logic [N-1:0]  rv;
  logic [DW-1:0] ra [N];
  logic [SW-1:0] rb [N];
  logic [N-1:0]  persist = '0;
  bit            rnd_mode = 0;
  logic [N-1:0]  hs_seen = '0;

  task automatic driveReq();
    for (int i = 0; i < N; i++) begin
      bus.req_valid[i]             = rv[i];
      bus.req_dividend[i*DW +: DW] = ra[i];
      bus.req_divisor[i*SW +: SW]  = rb[i];
    end
  endtask

  task automatic setReq(input int i, input logic [DW-1:0] a, input logic [SW-1:0] b);
    rv[i] = 1'b1;
    ra[i] = a;
    rb[i] = b;
    driveReq();
  endtask

  task automatic newOperand(input int i);
    rv[i] = 1'b1;
    ra[i] = {$urandom, $urandom};
    case ($urandom_range(7, 0))
      0:       rb[i] = '0;
      1, 2:    rb[i] = SW'($urandom_range(15, 1));
      default: rb[i] = $urandom;
    endcase
  endtask

  // One clock of requester behaviour: after a grant, re-request or drop.
  task automatic applyStimulus(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      for (int i = 0; i < N; i++) begin
        if (hs_seen[i]) begin
          if (persist[i] || (rnd_mode && $urandom_range(1, 0) == 1)) newOperand(i);
          else rv[i] = 1'b0;
        end else if (rnd_mode) begin
          if (!rv[i] && $urandom_range(3, 0) == 0) newOperand(i);
          else if (rv[i] && $urandom_range(15, 0) == 0) rv[i] = 1'b0;
        end
      end
      driveReq();
    end
  endtask

  task automatic doReset(input bit keep_req);
    reset = 1'b1;
    if (!keep_req) begin
      rv = '0;
      driveReq();
    end
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  // Behavioural divider: result appears stub_lat cycles after the start pulse.
  typedef struct {
    int            due;
    logic [DW-1:0] q;
    logic [SW-1:0] r;
    logic          ovf;
  } res_t;
  res_t pend[$];
  int   stub_lat = 1;
  bit   stray_inject = 0;
  int   issue_count = 0;

  always @(negedge clk) begin
    int   lat;
    res_t e;
    if (!reset && bus.div_valid_in) begin
      issue_count++;
      lat   = (stub_lat == 0) ? $urandom_range(5, 1) : stub_lat;
      e.due = cyc + lat;
      e.q   = (bus.div_divisor == '0) ? '1 : bus.div_dividend / {32'b0, bus.div_divisor};
      e.r   = (bus.div_divisor == '0) ? '0 : SW'(bus.div_dividend % {32'b0, bus.div_divisor});
      e.ovf = rnd_mode ? 1'($urandom_range(1, 0)) : 1'b0;
      pend.push_back(e);
    end
  end

  always @(posedge clk) begin
    res_t e;
    #1;
    while (pend.size() > 0 && pend[0].due < cyc) e = pend.pop_front();
    bus.div_valid_out = 1'b0;
    bus.div_quotient  = {$urandom, $urandom};
    bus.div_remainder = $urandom;
    bus.div_overflow  = 1'($urandom_range(1, 0));
    if (pend.size() > 0 && pend[0].due == cyc) begin
      e = pend.pop_front();
      bus.div_valid_out = 1'b1;
      bus.div_quotient  = e.q;
      bus.div_remainder = e.r;
      bus.div_overflow  = e.ovf;
    end else if (stray_inject && !bus.busy) begin
      bus.div_valid_out = 1'b1;
      stray_inject      = 0;
    end
  end

  // Reference model: one job at a time, described by its handshake and response cycles.
  bit            m_active = 0;
  bit            m_dbz;
  int            m_rr = 0;
  int            m_owner;
  int            m_hs;
  int            m_rsp;
  logic [DW-1:0] m_a;
  logic [SW-1:0] m_b;
  logic [DW-1:0] m_q;
  logic [SW-1:0] m_r;
  logic          m_ovf;
  bit            m_err_to = 0;
  bit            m_err_stray = 0;

  int            grant_q[$];
  int            last_grant_cyc = -1;
  int            rsp_count = 0;
  int            last_rsp_cyc = -1;
  logic [N-1:0]  last_rsp_vec;
  logic [DW-1:0] last_rsp_q;
  logic [SW-1:0] last_rsp_r;
  logic          last_rsp_ovf;

  always @(negedge clk) begin
    int           win;
    int           idx;
    bit           in_wait;
    logic [N-1:0] exp_ready;
    logic [N-1:0] exp_rsp;
    bit           exp_dvi;
    if (reset) begin
      m_active    = 0;
      m_rr        = 0;
      m_err_to    = 0;
      m_err_stray = 0;
      hs_seen     = '0;
    end else begin
      win = -1;
      if (!m_active) begin
        for (int k = 0; k < N; k++) begin
          idx = (m_rr + k) % N;
          if (win < 0 && bus.req_valid[idx]) win = idx;
        end
      end
      exp_ready = (win >= 0) ? N'(1) << win : '0;
      exp_dvi   = m_active && !m_dbz && cyc == m_hs + 1;
      exp_rsp   = (m_active && cyc == m_rsp) ? N'(1) << m_owner : '0;

      checkOutput("req_ready", 64'(bus.req_ready), 64'(exp_ready));
      checkOutput("div_valid_in", 64'(bus.div_valid_in), 64'(exp_dvi));
      checkOutput("rsp_valid", 64'(bus.rsp_valid), 64'(exp_rsp));
      checkOutput("busy", 64'(bus.busy), 64'(m_active));
      checkOutput("err_timeout", 64'(bus.err_timeout), 64'(m_err_to));
      checkOutput("err_stray", 64'(bus.err_stray), 64'(m_err_stray));
      if (exp_dvi) begin
        checkOutput("div_dividend", bus.div_dividend, m_a);
        checkOutput("div_divisor", 64'(bus.div_divisor), 64'(m_b));
      end
      if (exp_rsp != '0) begin
        checkOutput("rsp_quotient", bus.rsp_quotient, m_q);
        checkOutput("rsp_remainder", 64'(bus.rsp_remainder), 64'(m_r));
        checkOutput("rsp_overflow", 64'(bus.rsp_overflow), 64'(m_ovf));
      end

      hs_seen = bus.req_valid & bus.req_ready;
      for (int i = 0; i < N; i++) begin
        if (hs_seen[i]) begin
          grant_q.push_back(i);
          last_grant_cyc = cyc;
        end
      end
      if (bus.rsp_valid != '0) begin
        rsp_count++;
        last_rsp_cyc = cyc;
        last_rsp_vec = bus.rsp_valid;
        last_rsp_q   = bus.rsp_quotient;
        last_rsp_r   = bus.rsp_remainder;
        last_rsp_ovf = bus.rsp_overflow;
      end

      in_wait = m_active && !m_dbz && cyc >= m_hs + 2 && m_rsp < 0;
      if (bus.div_valid_out && !in_wait) m_err_stray = 1;
      if (in_wait) begin
        if (bus.div_valid_out) begin
          m_rsp = cyc + 1;
          m_q   = m_a / {32'b0, m_b};
          m_r   = SW'(m_a % {32'b0, m_b});
          m_ovf = bus.div_overflow;
        end else if (cyc == m_hs + 1 + TO) begin
          m_rsp    = cyc + 1;
          m_q      = '1;
          m_r      = '0;
          m_ovf    = 1'b1;
          m_err_to = 1;
        end
      end
      if (m_active && cyc == m_rsp) begin
        m_active = 0;
        m_rr     = (m_owner + 1) % N;
      end else if (!m_active && win >= 0) begin
        m_active = 1;
        m_owner  = win;
        m_hs     = cyc;
        m_a      = bus.req_dividend[win*DW +: DW];
        m_b      = bus.req_divisor[win*SW +: SW];
        m_dbz    = (m_b == '0);
        if (m_dbz) begin
          m_rsp = cyc + 1;
          m_q   = '1;
          m_r   = '0;
          m_ovf = 1'b1;
        end else begin
          m_rsp = -1;
        end
      end
    end
  end

  task automatic waitRsp(input int limit);
    int rc;
    int n;
    rc = rsp_count;
    n  = 0;
    while (rsp_count == rc && n < limit) begin
      applyStimulus(1);
      n++;
    end
    if (rsp_count == rc) checkOutput("rsp_wait_expired", 64'(0), 64'(1));
  endtask

  task automatic waitGrants(input int count, input int limit);
    int n;
    n = 0;
    while (grant_q.size() < count && n < limit) begin
      applyStimulus(1);
      n++;
    end
  endtask

  initial begin
    int ic;
    int rc;
    reset = 1'b1;
    rv    = '0;
    for (int i = 0; i < N; i++) begin
      ra[i] = '0;
      rb[i] = '0;
    end
    driveReq();
    bus.div_valid_out = 1'b0;
    bus.div_quotient  = '0;
    bus.div_remainder = '0;
    bus.div_overflow  = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset_busy", 64'(bus.busy), 64'(0));
    checkOutput("reset_rsp_valid", 64'(bus.rsp_valid), 64'(0));
    checkOutput("reset_div_valid_in", 64'(bus.div_valid_in), 64'(0));
    checkOutput("reset_div_dividend", bus.div_dividend, 64'(0));
    checkOutput("reset_rsp_quotient", bus.rsp_quotient, 64'(0));
    checkOutput("reset_errs", {62'b0, bus.err_timeout, bus.err_stray}, 64'(0));
    reset = 1'b0;

    $display("[TB] single request 1000/7");
    stub_lat = 1;
    ic = issue_count;
    setReq(0, 64'd1000, 32'd7);
    waitRsp(40);
    checkOutput("single_latency", 64'(last_rsp_cyc - last_grant_cyc), 64'(3));
    checkOutput("single_vec", 64'(last_rsp_vec), 64'b01);
    checkOutput("single_quotient", last_rsp_q, 64'd142);
    checkOutput("single_remainder", 64'(last_rsp_r), 64'd6);
    checkOutput("single_overflow", 64'(last_rsp_ovf), 64'd0);
    checkOutput("single_issues", 64'(issue_count - ic), 64'd1);
    applyStimulus(4);

    $display("[TB] contention from reset");
    stub_lat = 0;
    reset    = 1'b1;
    newOperand(0);
    newOperand(1);
    rb[0] = 32'd3;
    rb[1] = 32'd5;
    driveReq();
    persist = 2'b11;
    grant_q.delete();
    doReset(1);
    waitGrants(4, 200);
    checkOutput("contention_count", 64'(grant_q.size() >= 4), 64'(1));
    checkOutput("contention_g0", 64'(grant_q[0]), 64'(0));
    checkOutput("contention_g1", 64'(grant_q[1]), 64'(1));
    checkOutput("contention_g2", 64'(grant_q[2]), 64'(0));
    checkOutput("contention_g3", 64'(grant_q[3]), 64'(1));
    persist = '0;
    applyStimulus(40);

    $display("[TB] starvation");
    doReset(0);
    grant_q.delete();
    persist = 2'b01;
    newOperand(0);
    newOperand(1);
    driveReq();
    waitGrants(3, 200);
    checkOutput("starve_first", 64'(grant_q[0]), 64'(0));
    checkOutput("starve_second", 64'(grant_q[1]), 64'(1));
    persist = '0;
    applyStimulus(40);

    $display("[TB] divide by zero");
    ic = issue_count;
    setReq(1, 64'd5, 32'd0);
    waitRsp(40);
    checkOutput("dbz_latency", 64'(last_rsp_cyc - last_grant_cyc), 64'(1));
    checkOutput("dbz_vec", 64'(last_rsp_vec), 64'b10);
    checkOutput("dbz_quotient", last_rsp_q, 64'hFFFF_FFFF_FFFF_FFFF);
    checkOutput("dbz_remainder", 64'(last_rsp_r), 64'd0);
    checkOutput("dbz_overflow", 64'(last_rsp_ovf), 64'd1);
    checkOutput("dbz_issues", 64'(issue_count - ic), 64'd0);
    applyStimulus(4);

    $display("[TB] result on the last watchdog cycle");
    stub_lat = TO;
    setReq(0, 64'd1000003, 32'd1000);
    waitRsp(60);
    checkOutput("edge_latency", 64'(last_rsp_cyc - last_grant_cyc), 64'(TO + 2));
    checkOutput("edge_quotient", last_rsp_q, 64'd1000);
    checkOutput("edge_remainder", 64'(last_rsp_r), 64'd3);
    checkOutput("edge_overflow", 64'(last_rsp_ovf), 64'd0);
    checkOutput("edge_no_timeout", 64'(bus.err_timeout), 64'd0);
    applyStimulus(4);

    $display("[TB] timeout then late result");
    stub_lat = TO + 1;
    setReq(1, 64'd77, 32'd3);
    waitRsp(60);
    checkOutput("tmo_latency", 64'(last_rsp_cyc - last_grant_cyc), 64'(TO + 2));
    checkOutput("tmo_vec", 64'(last_rsp_vec), 64'b10);
    checkOutput("tmo_quotient", last_rsp_q, 64'hFFFF_FFFF_FFFF_FFFF);
    checkOutput("tmo_remainder", 64'(last_rsp_r), 64'd0);
    checkOutput("tmo_overflow", 64'(last_rsp_ovf), 64'd1);
    applyStimulus(3);
    checkOutput("tmo_err_timeout", 64'(bus.err_timeout), 64'd1);
    checkOutput("tmo_err_stray", 64'(bus.err_stray), 64'd1);

    $display("[TB] reset during wait");
    doReset(0);
    stub_lat = 7;
    ic       = grant_q.size();
    setReq(0, 64'd1000, 32'd7);
    begin
      int n;
      n = 0;
      while (grant_q.size() == ic && n < 50) begin
        applyStimulus(1);
        n++;
      end
    end
    applyStimulus(2);
    rc = rsp_count;
    doReset(0);
    applyStimulus(12);
    checkOutput("abort_no_rsp", 64'(rsp_count - rc), 64'd0);
    checkOutput("abort_err_stray", 64'(bus.err_stray), 64'd1);
    checkOutput("abort_err_timeout", 64'(bus.err_timeout), 64'd0);
    stub_lat = 2;
    setReq(1, 64'd100, 32'd9);
    waitRsp(40);
    checkOutput("fresh_latency", 64'(last_rsp_cyc - last_grant_cyc), 64'(4));
    checkOutput("fresh_vec", 64'(last_rsp_vec), 64'b10);
    checkOutput("fresh_quotient", last_rsp_q, 64'd11);
    checkOutput("fresh_remainder", 64'(last_rsp_r), 64'd1);
    applyStimulus(4);

    $display("[TB] randomized traffic");
    doReset(0);
    stub_lat = 0;
    rnd_mode = 1;
    applyStimulus(1500);
    stray_inject = 1;
    applyStimulus(1500);
    rnd_mode = 0;
    rv       = '0;
    driveReq();
    applyStimulus(40);
    checkOutput("random_traffic_seen", 64'(rsp_count > 100), 64'd1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
